// File: rtl/m2_sram_arbiter.sv
// rtl/m2_sram_arbiter.sv - two-requester (fetch read / write-back) single-port SRAM arbiter
module m2_sram_arbiter #(
    parameter int READ_LATENCY = 2,
    parameter int MAX_BURST    = 64
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        FS_req,
    input  logic        FS_last,
    input  logic [17:0] FS_address,
    output logic        FS_grant,
    output logic        FS_rd_valid,
    output logic [15:0] FS_rd_data,
    input  logic        WS_req,
    input  logic        WS_last,
    input  logic [17:0] WS_address,
    input  logic [15:0] WS_write_data,
    output logic        WS_grant,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    input  logic [15:0] SRAM_read_data,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, GRANT_FS, GRANT_WS, TURN} state_t;

    state_t              state_q;
    logic                ready_q;
    logic                last_ws_q;
    logic                fs_grant_q;
    logic                ws_grant_q;
    logic                we_n_q;
    logic [17:0]         addr_q;
    logic [15:0]         wdata_q;
    logic [6:0]          count_q;
    logic [6:0]          count_d;
    logic [READ_LATENCY:0] tag_q;

    logic fs_beat;
    logic ws_beat;
    logic beat;
    logic other_req;
    logic cur_last;
    logic burst_end;
    logic pick_fs;
    logic arb_go;

    always_comb begin
        fs_beat   = fs_grant_q & FS_req;
        ws_beat   = ws_grant_q & WS_req;
        beat      = fs_beat | ws_beat;
        other_req = fs_grant_q ? WS_req : FS_req;
        cur_last  = fs_grant_q ? FS_last : WS_last;
        count_d   = (beat && count_q != 7'h7f) ? count_q + 7'd1 : count_q;
        // Preemption can also fire on a stall once the beat limit has been reached.
        burst_end = (fs_grant_q | ws_grant_q) &
                    ((beat & cur_last) | (other_req & (count_d >= 7'(MAX_BURST))));
        pick_fs   = FS_req & (~WS_req | last_ws_q);
        // ready_q delays the first arbitration by one edge after reset release.
        arb_go    = ready_q & (FS_req | WS_req);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            last_ws_q  <= 1'b1;
            fs_grant_q <= 1'b0;
            ws_grant_q <= 1'b0;
            we_n_q     <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            count_q    <= '0;
            tag_q      <= '0;
        end else begin
            ready_q <= 1'b1;
            tag_q   <= {tag_q[READ_LATENCY-1:0], fs_beat};
            we_n_q  <= ~ws_beat;
            if (fs_beat) begin
                addr_q <= FS_address;
            end else if (ws_beat) begin
                addr_q  <= WS_address;
                wdata_q <= WS_write_data;
            end
            case (state_q)
                IDLE, TURN: begin
                    if (arb_go) begin
                        count_q <= '0;
                        if (pick_fs) begin
                            state_q    <= GRANT_FS;
                            fs_grant_q <= 1'b1;
                        end else begin
                            state_q    <= GRANT_WS;
                            ws_grant_q <= 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                GRANT_FS, GRANT_WS: begin
                    count_q <= count_d;
                    if (burst_end) begin
                        state_q    <= TURN;
                        fs_grant_q <= 1'b0;
                        ws_grant_q <= 1'b0;
                        last_ws_q  <= ws_grant_q;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    fs_grant_q <= 1'b0;
                    ws_grant_q <= 1'b0;
                end
            endcase
        end
    end

    assign FS_grant        = fs_grant_q;
    assign WS_grant        = ws_grant_q;
    assign SRAM_address    = addr_q;
    assign SRAM_write_data = wdata_q;
    assign SRAM_we_n       = we_n_q;
    assign FS_rd_valid     = tag_q[READ_LATENCY];
    assign FS_rd_data      = SRAM_read_data;
    assign busy            = (state_q != IDLE) | (|tag_q);

endmodule

// File: tb/tb_m2_sram_arbiter.sv
// tb/tb_m2_sram_arbiter.sv - self-checking bench for m2_sram_arbiter
module tb_m2_sram_arbiter;
    localparam int RL   = 2;
    localparam int MAXB = 64;

    logic        clk = 1'b0;
    logic        Resetn = 1'b1;
    logic        FS_req = 1'b0, FS_last = 1'b0;
    logic [17:0] FS_address = '0;
    logic        WS_req = 1'b0, WS_last = 1'b0;
    logic [17:0] WS_address = '0;
    logic [15:0] WS_write_data = '0;
    logic        FS_grant, FS_rd_valid, WS_grant, SRAM_we_n, busy;
    logic [15:0] FS_rd_data, SRAM_write_data, SRAM_read_data;
    logic [17:0] SRAM_address;

    m2_sram_arbiter #(.READ_LATENCY(RL), .MAX_BURST(MAXB)) dut (
        .Clock(clk), .Resetn(Resetn),
        .FS_req(FS_req), .FS_last(FS_last), .FS_address(FS_address),
        .FS_grant(FS_grant), .FS_rd_valid(FS_rd_valid), .FS_rd_data(FS_rd_data),
        .WS_req(WS_req), .WS_last(WS_last), .WS_address(WS_address),
        .WS_write_data(WS_write_data), .WS_grant(WS_grant),
        .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
        .SRAM_we_n(SRAM_we_n), .SRAM_read_data(SRAM_read_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int tb_cyc  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, tb_cyc);
        end
    endtask

    function automatic logic [15:0] sram_fn(input logic [17:0] a);
        return a[15:0] ^ {a[17:16], 14'h1A5C};
    endfunction

    // SRAM: data for the registered address appears RL cycles later
    logic [17:0] pa1 = '0, pa2 = '0;
    always @(posedge clk) begin
        pa1 <= SRAM_address;
        pa2 <= pa1;
        tb_cyc <= tb_cyc + 1;
    end
    assign SRAM_read_data = sram_fn(pa2);

    // Reference model: owner 0=none 1=FS 2=WS, reads tracked as due-cycle queue
    int          m_owner = 0, m_beats = 0;
    bit          m_turn = 0, m_ready = 0, m_last_fs = 0, m_we_n = 1;
    bit          m_fsb, m_wsb, m_other, m_lastf;
    logic [17:0] m_addr = '0;
    logic [15:0] m_wdata = '0;
    int          due_q[$];
    logic [17:0] exp_a_q[$];

    always @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            m_owner = 0; m_beats = 0; m_turn = 0; m_ready = 0; m_last_fs = 0;
            m_we_n = 1; m_addr = '0; m_wdata = '0;
            due_q.delete(); exp_a_q.delete();
        end else begin
            m_fsb = (m_owner == 1) && FS_req;
            m_wsb = (m_owner == 2) && WS_req;
            m_we_n = !m_wsb;
            if (m_fsb) begin
                m_addr = FS_address;
                due_q.push_back(tb_cyc + 1 + RL);
                exp_a_q.push_back(FS_address);
            end
            if (m_wsb) begin
                m_addr = WS_address;
                m_wdata = WS_write_data;
            end
            if (m_fsb || m_wsb) m_beats = (m_beats < 127) ? m_beats + 1 : 127;
            if (m_owner != 0) begin
                m_other = (m_owner == 1) ? WS_req : FS_req;
                m_lastf = (m_owner == 1) ? FS_last : WS_last;
                if (((m_fsb || m_wsb) && m_lastf) || (m_other && m_beats >= MAXB)) begin
                    m_last_fs = (m_owner == 1);
                    m_owner = 0;
                    m_turn = 1;
                end
            end else if (m_ready && (FS_req || WS_req)) begin
                m_owner = (FS_req && (!WS_req || !m_last_fs)) ? 1 : 2;
                m_beats = 0;
                m_turn = 0;
            end else begin
                m_turn = 0;
            end
            m_ready = 1;
        end
    end

    bit exp_v;
    always @(negedge clk) begin
        exp_v = (due_q.size() > 0) && (due_q[0] == tb_cyc);
        chk("FS_grant", FS_grant, m_owner == 1);
        chk("WS_grant", WS_grant, m_owner == 2);
        chk("SRAM_we_n", SRAM_we_n, m_we_n);
        chk("SRAM_address", SRAM_address, m_addr);
        chk("SRAM_write_data", SRAM_write_data, m_wdata);
        chk("busy", busy, (m_owner != 0) || m_turn || (due_q.size() > 0));
        chk("FS_rd_valid", FS_rd_valid, exp_v);
        if (exp_v) begin
            chk("FS_rd_data", FS_rd_data, sram_fn(exp_a_q[0]));
            void'(due_q.pop_front());
            void'(exp_a_q.pop_front());
        end
    end

    int r_fi, r_wi, r_iter, r_pulses, r_pulses_nofs, r_we_low;
    int r_fs_first, r_ws_first, r_fi_at_ws, r_wi_at_fs, r_first_beat, r_first_valid;

    task automatic observe();
        if (FS_rd_valid) begin
            r_pulses++;
            if (!FS_grant) r_pulses_nofs++;
            if (r_first_valid < 0) r_first_valid = tb_cyc;
        end
        if (!SRAM_we_n) r_we_low++;
    endtask

    task automatic clear_stats();
        r_fi = 0; r_wi = 0; r_iter = 0; r_pulses = 0; r_pulses_nofs = 0; r_we_low = 0;
        r_fs_first = -1; r_ws_first = -1; r_fi_at_ws = -1; r_wi_at_fs = -1;
        r_first_beat = -1; r_first_valid = -1;
    endtask

    task automatic run(input int fs_n, input int ws_n, input int fs_base, input int ws_base,
                       input int fs_delay, input bit ws_last_en);
        clear_stats();
        while ((r_fi < fs_n || r_wi < ws_n) && r_iter < 400) begin
            @(negedge clk);
            observe();
            FS_req        = (r_fi < fs_n) && (r_iter >= fs_delay);
            FS_address    = 18'(fs_base + r_fi);
            FS_last       = (r_fi == fs_n - 1);
            WS_req        = (r_wi < ws_n);
            WS_address    = 18'(ws_base + r_wi);
            WS_write_data = 16'(32'hC000 + r_wi);
            WS_last       = ws_last_en && (r_wi == ws_n - 1);
            if (FS_grant && r_fs_first < 0) begin r_fs_first = r_iter; r_wi_at_fs = r_wi; end
            if (WS_grant && r_ws_first < 0) begin r_ws_first = r_iter; r_fi_at_ws = r_fi; end
            if (FS_grant && FS_req) begin
                if (r_first_beat < 0) r_first_beat = tb_cyc;
                r_fi++;
            end
            if (WS_grant && WS_req) r_wi++;
            r_iter++;
        end
        chk("run_completed_in_budget", r_iter < 400, 1'b1);
        repeat (8) begin
            @(negedge clk);
            observe();
            FS_req = 0; WS_req = 0; FS_last = 0; WS_last = 0;
        end
    endtask

    int waitc;
    initial begin
        #1 Resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_we_n", SRAM_we_n, 1'b1);
        chk("reset_address", SRAM_address, 18'd0);

        // FS burst of 8 from 76800; first grant on the second edge after release
        FS_req = 1; FS_address = 18'd76800;
        #2 Resetn = 1'b1;
        run(8, 0, 76800, 0, 0, 0);
        chk("fs8_first_grant_iter", r_fs_first, 1);
        chk("fs8_pulses", r_pulses, 8);
        chk("fs8_read_latency", r_first_valid - r_first_beat, 3);
        chk("fs8_no_writes", r_we_low, 0);

        // Reset mid-FS burst with two reads in flight
        clear_stats();
        FS_req = 1; FS_address = 18'd2000; FS_last = 0;
        waitc = 0;
        @(negedge clk);
        while (!FS_grant && waitc < 10) begin @(negedge clk); waitc++; end
        chk("abort_grant_seen", FS_grant, 1'b1);
        @(negedge clk); FS_address = 18'd2001;
        @(negedge clk); FS_req = 0;
        #2 Resetn = 1'b0;
        @(negedge clk);
        #2 Resetn = 1'b1;
        repeat (10) begin @(negedge clk); observe(); end
        chk("abort_no_pulses", r_pulses, 0);
        chk("abort_idle_busy", busy, 1'b0);
        chk("abort_we_n", SRAM_we_n, 1'b1);

        // Tie after reset: FS first, TURN, then WS
        run(3, 3, 3000, 100, 0, 1);
        chk("tie_fs_first_iter", r_fs_first, 1);
        chk("tie_fs_done_at_ws", r_fi_at_ws, 3);
        chk("tie_ws_gap", r_ws_first - r_fs_first, 4);
        chk("tie_writes", r_we_low, 3);

        // FS burst of 4 then WS: returns survive the switch
        run(4, 2, 4000, 200, 0, 1);
        chk("switch_pulses", r_pulses, 4);
        chk("switch_pulses_not_fs", r_pulses_nofs, 3);

        // WS stall: req 1,0,1 gives exactly two writes
        clear_stats();
        WS_req = 1; WS_address = 18'd300; WS_write_data = 16'hBEEF; WS_last = 0;
        waitc = 0;
        @(negedge clk);
        while (!WS_grant && waitc < 10) begin @(negedge clk); waitc++; end
        chk("stall_grant_seen", WS_grant, 1'b1);
        @(negedge clk); observe(); WS_req = 0;
        chk("stall_grant_held", WS_grant, 1'b1);
        @(negedge clk); observe();
        chk("stall_we_n_high", SRAM_we_n, 1'b1);
        chk("stall_grant_held2", WS_grant, 1'b1);
        WS_req = 1; WS_address = 18'd301; WS_write_data = 16'hCAFE; WS_last = 1;
        @(negedge clk); observe(); WS_req = 0; WS_last = 0;
        repeat (5) begin @(negedge clk); observe(); end
        chk("stall_writes", r_we_low, 2);

        // WS 70 beats with FS waiting: preempt after 64
        run(4, 70, 5000, 1000, 10, 1);
        chk("preempt_ws_beats_before_fs", r_wi_at_fs, 64);
        chk("preempt_ws_total", r_wi, 70);
        chk("preempt_writes", r_we_low, 70);
        chk("preempt_fs_pulses", r_pulses, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/m2_sram_arbiter.md
M2_SRAM_ARBITER -- requirements
Module: m2_sram_arbiter

Interface
REQ-001 Parameter READ_LATENCY, default 2: SRAM cycles from a registered address to valid SRAM_read_data.
REQ-002 Parameter MAX_BURST, default 64: beats after which a grant is preempted if the other requester is waiting.
REQ-003 Clock  input  1  single clock; all logic on the rising edge.
REQ-004 Resetn  input  1  asynchronous, active-low reset.
REQ-005 FS_req  input  1  fetch (S' read) requester wants the port / presents a beat.
REQ-006 FS_last  input  1  current FS beat is the final beat of its burst.
REQ-007 FS_address  input  18  FS read address.
REQ-008 FS_grant  output  1  FS owns the port.
REQ-009 FS_rd_valid  output  1  FS_rd_data holds read data for an earlier FS beat.
REQ-010 FS_rd_data  output  16  read data, equal to SRAM_read_data.
REQ-011 WS_req  input  1  write-back (S) requester wants the port / presents a beat.
REQ-012 WS_last  input  1  current WS beat is the final beat of its burst.
REQ-013 WS_address  input  18  WS write address.
REQ-014 WS_write_data  input  16  WS write data.
REQ-015 WS_grant  output  1  WS owns the port.
REQ-016 SRAM_address  output  18  registered SRAM address.
REQ-017 SRAM_write_data  output  16  registered SRAM write data.
REQ-018 SRAM_we_n  output  1  registered write enable, active low.
REQ-019 SRAM_read_data  input  16  SRAM read data.
REQ-020 busy  output  1  high in any state other than IDLE, or while any read tag is in flight.

Function
REQ-021 States: IDLE, GRANT_FS, GRANT_WS, TURN.
- FS_grant is high only in GRANT_FS.
- WS_grant is high only in GRANT_WS.
- All grant outputs are registered.
REQ-022 IDLE arbitration:
- Only one req high: go to that requester's GRANT state.
- Both high: grant the requester not served last. last_served resets to WS, so FS wins the first tie.
- Neither high: stay in IDLE.
REQ-023 A beat is any cycle with grant=1 and the matching req=1.
- req=0 while granted is a stall: no beat, no SRAM write, grant held.
REQ-024 FS beat: SRAM_address <= FS_address; SRAM_we_n <= 1.
REQ-025 WS beat: SRAM_address <= WS_address; SRAM_write_data <= WS_write_data; SRAM_we_n <= 0.
REQ-026 Non-beat cycles: SRAM_we_n <= 1. SRAM_address and SRAM_write_data hold their values.
REQ-027 Read return:
- FS beat at cycle t gives FS_rd_valid=1 at cycle t+1+READ_LATENCY.
- Tracked by a tag shift register of depth READ_LATENCY+1.
- Returns one valid pulse per beat, in order, with no loss across back-to-back beats.
REQ-028 Burst end: a beat with last=1, or a preempt, moves to TURN and updates last_served.
REQ-029 TURN lasts exactly 1 cycle (no grant, SRAM_we_n=1), then re-arbitrates as in IDLE with the same rules.
- TURN is never skipped, even when the same requester is next.
REQ-030 Beat counter, 7 bits:
- Clears on each grant and increments per beat.
- Preempt when count reaches MAX_BURST and the other req=1.
- If the other req=0, the burst continues and the counter saturates.
REQ-031 A preempted requester keeps req high and re-enters arbitration. The next grant restarts its counter.
REQ-032 FS_rd_valid is unaffected by grant changes: reads issued before a switch still return while WS is granted.
REQ-033 Read and write never share a cycle; at most one beat per cycle.

Reset
REQ-034 Resetn=0, at any time including mid-burst:
- state=IDLE, grants=0, SRAM_we_n=1, SRAM_address=0, SRAM_write_data=0.
- Tag pipeline cleared, FS_rd_valid=0, counter=0, last_served=WS, busy=0.
- In-flight reads are dropped.
REQ-035 First grant is possible on the second rising edge after Resetn rises.

Verification
REQ-036 FS_req=1 alone, FS_address=76800..76807, FS_last on the 8th beat -> FS_grant 8 beats, then TURN; FS_rd_valid pulses 3 cycles after each beat; data matches SRAM model.
REQ-037 FS_req and WS_req both rise in IDLE after reset -> FS granted first; on FS_last, TURN 1 cycle, then WS_grant; SRAM_we_n=0 only on WS beats.
REQ-038 WS burst of 70 beats, no WS_last, FS_req=1 waiting -> preempt after beat 64, TURN, FS granted; WS re-granted after FS_last with its counter reset.
REQ-039 WS granted, WS_req toggles 1,0,1 -> exactly 2 writes, SRAM_we_n=1 in the stall cycle, grant held.
REQ-040 FS burst of 4, then WS immediately -> all 4 FS_rd_valid pulses arrive, including those arriving during TURN/GRANT_WS.
REQ-041 Resetn pulsed low mid-FS burst with 2 reads in flight -> FS_rd_valid stays 0 afterward, SRAM_we_n=1, state IDLE, next tie grants FS.
